// File: rtl/ascii_pkg.sv
// Shared ASCII constants, streamer state encoding and the leading-zero blanking helper.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } streamerState_t;

    function automatic logic [7:0] blank_char(input logic [7:0] ch, input logic lead, input logic notLast);
        return (lead && notLast && (ch == ASCII_ZERO)) ? ASCII_SPACE : ch;
    endfunction

endpackage

// File: rtl/ascii_digit_streamer.sv
// Snapshots a packed ASCII string on start and streams it MSD first; ASCII_LEADING_ZERO_BLANK_EN blanks leading '0's.
// Latency: start at edge n -> first character valid at n+1; one character per cycle while charReady is high.
// Backpressure: charValid/charData/charIndex/lastChar hold until charReady; start is ignored while busy.
module ascii_digit_streamer
    import ascii_pkg::*;
#(
    parameter int DIGIT_COUNT = 4,
    localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     start,
    input  logic [8*DIGIT_COUNT-1:0] asciiInput,
    output logic                     charValid,
    input  logic                     charReady,
    output logic [7:0]               charData,
    output logic [IDX_W-1:0]         charIndex,
    output logic                     lastChar,
    output logic                     busy,
    output logic                     done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGIT_COUNT - 1);

    streamerState_t           state;
    logic [8*DIGIT_COUNT-1:0] snap;
    logic [IDX_W-1:0]         nextIdx;
    logic [7:0]               firstRaw;
    logic [7:0]               nextRaw;
    logic [7:0]               firstChar;
    logic [7:0]               nextChar;

    function automatic logic [7:0] char_at(input logic [8*DIGIT_COUNT-1:0] v, input logic [IDX_W-1:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < DIGIT_COUNT; k++) begin
            if (i == IDX_W'(k)) begin
                r = v[8*(DIGIT_COUNT-1-k) +: 8];
            end
        end
        return r;
    endfunction

    assign nextIdx  = charIndex + 1'b1;
    assign firstRaw = asciiInput[8*DIGIT_COUNT-1 -: 8];
    assign nextRaw  = char_at(snap, nextIdx);

`ifdef ASCII_LEADING_ZERO_BLANK_EN
    // lead is the leading-zone flag as seen by the character currently presented.
    logic       lead;
    logic       leadNext;
    logic [7:0] curRaw;

    assign curRaw    = char_at(snap, charIndex);
    assign leadNext  = lead && (curRaw == ASCII_ZERO);
    assign firstChar = blank_char(firstRaw, 1'b1, LAST_IDX != '0);
    assign nextChar  = blank_char(nextRaw, leadNext, nextIdx != LAST_IDX);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            lead <= 1'b0;
        end else if (state == IDLE && start) begin
            lead <= 1'b1;
        end else if (state == SEND && charReady && charIndex != LAST_IDX) begin
            lead <= leadNext && (nextIdx != LAST_IDX);
        end
    end
`else
    assign firstChar = firstRaw;
    assign nextChar  = nextRaw;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            snap      <= '0;
            charData  <= 8'h00;
            charIndex <= '0;
            lastChar  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEND;
                        snap      <= asciiInput;
                        charIndex <= '0;
                        charData  <= firstChar;
                        lastChar  <= (LAST_IDX == '0);
                    end
                end
                SEND: begin
                    if (charReady) begin
                        if (charIndex == LAST_IDX) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            lastChar <= 1'b0;
                        end else begin
                            charIndex <= nextIdx;
                            charData  <= nextChar;
                            lastChar  <= (nextIdx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign charValid = (state == SEND);
    assign busy      = (state == SEND);

endmodule
